// File: rtl/flow_pair_arbiter_pkg.sv
// rtl/flow_pair_arbiter_pkg.sv - shared state encoding and width helper for the pair arbiter
package flow_pair_arbiter_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_LOCK = 1'b1
   } state_t;

   // Index width for n items, never narrower than one bit.
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/flow_pair_arbiter_rr_pick.sv
// rtl/flow_pair_arbiter_rr_pick.sv - first requester searching upward from a start index, wrapping at NUM_SRC-1
module rr_pick
   import flow_pair_arbiter_pkg::*;
#(
   parameter int NUM_SRC = 4,
   localparam int ID_W = clog2_min1(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [ID_W-1:0]    start,
   output logic               any,
   output logic [ID_W-1:0]    idx
);

   int cand;

   // Walk from the farthest candidate back to start so the nearest requester wins.
   always_comb begin
      any  = 1'b0;
      idx  = '0;
      cand = 0;
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
         cand = int'(start) + k;
         if (cand >= NUM_SRC) cand = cand - NUM_SRC;
         if (req[cand]) begin
            any = 1'b1;
            idx = ID_W'(cand);
         end
      end
   end

endmodule

// File: rtl/flow_pair_arbiter.sv
// rtl/flow_pair_arbiter.sv - round-robin valid/ready arbiter holding each grant for BEATS transfers
module flow_pair_arbiter
   import flow_pair_arbiter_pkg::*;
#(
   parameter int NUM_SRC = 4,
   parameter int DWIDTH  = 8,
   parameter int BEATS   = 2,
   localparam int ID_W   = clog2_min1(NUM_SRC)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cfg_en,
   input  logic [NUM_SRC-1:0]        src_val,
   output logic [NUM_SRC-1:0]        src_rdy,
   input  logic [NUM_SRC*DWIDTH-1:0] src_data,
   output logic                      dst_val,
   input  logic                      dst_rdy,
   output logic [DWIDTH-1:0]         dst_data,
   output logic [ID_W-1:0]           dst_src_id,
   output logic                      busy
);

   localparam int CNT_W = clog2_min1(BEATS);
   localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_SRC - 1);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   state_t           state;
   logic [ID_W-1:0]  gnt;
   logic [ID_W-1:0]  rr_ptr;
   logic [CNT_W-1:0] beat_cnt;

   logic             locked;
   logic             xfer;
   logic             last_xfer;
   logic [ID_W-1:0]  gnt_succ;
   logic [ID_W-1:0]  pick_start;
   logic             pick_any;
   logic [ID_W-1:0]  pick_idx;

   assign locked     = (state == ST_LOCK);
   assign gnt_succ   = (gnt == LAST_ID) ? '0 : gnt + 1'b1;
   // On a handoff the current owner must be considered last, so search from its successor.
   assign pick_start = locked ? gnt_succ : rr_ptr;

   rr_pick #(
      .NUM_SRC (NUM_SRC)
   ) u_pick (
      .req   (src_val),
      .start (pick_start),
      .any   (pick_any),
      .idx   (pick_idx)
   );

   assign dst_val    = locked & src_val[gnt];
   assign dst_data   = locked ? src_data[int'(gnt) * DWIDTH +: DWIDTH] : '0;
   assign dst_src_id = gnt;
   assign busy       = locked;
   assign xfer       = dst_val & dst_rdy;
   assign last_xfer  = xfer && (beat_cnt == LAST_BEAT);

   always_comb begin
      src_rdy = '0;
      if (locked) src_rdy[gnt] = dst_rdy;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         gnt      <= '0;
         rr_ptr   <= '0;
         beat_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cfg_en && pick_any) begin
                  gnt      <= pick_idx;
                  beat_cnt <= '0;
                  state    <= ST_LOCK;
               end
            end
            ST_LOCK: begin
               if (last_xfer) begin
                  rr_ptr   <= gnt_succ;
                  beat_cnt <= '0;
                  if (cfg_en && pick_any) gnt <= pick_idx;
                  else                    state <= ST_IDLE;
               end else if (xfer) begin
                  beat_cnt <= beat_cnt + 1'b1;
               end
            end
         endcase
      end
   end

endmodule
